// File: rtl/ps2_pkg.sv
// Shared types and frame geometry for the PS/2 receive path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   ps2_state_t  receive sequencer states
//   ps2_err_t    2-bit discard reason reported with errValid
//   FRAME_BITS / STOP_IDX / PARITY_IDX  bit positions within an 11-bit frame (start = 0)
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        CHECK   = 2'd2,
        PRESENT = 2'd3
    } ps2_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_PARITY  = 2'b01,
        ERR_FRAMING = 2'b10,
        ERR_TIMEOUT = 2'b11
    } ps2_err_t;

    localparam int FRAME_BITS = 11;
    localparam int STOP_IDX   = 10;
    localparam int PARITY_IDX = 9;

endpackage

// File: rtl/ps2_sync_filter.sv
// Pin front end: synchronises keyClk/keyData, glitch-filters keyClk, flags its falling edges.
// Latency: pin edge to fallEdge = SYNC_STAGES + FILTER_LEN sysClock cycles.
// Backpressure: none; free-running.
//
// Ports:
//   sysClock, sysReset_n  clock / async active-low reset
//   keyClk, keyData       raw asynchronous PS/2 pins
//   fallEdge              one-cycle pulse on each accepted 1->0 of the filtered clock
//   dataSync              synchronised keyData, to be sampled while fallEdge is high
module ps2_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic sysClock,
    input  logic sysReset_n,
    input  logic keyClk,
    input  logic keyData,
    output logic fallEdge,
    output logic dataSync
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [SYNC_STAGES-1:0] clkSync;
    logic [SYNC_STAGES-1:0] datSync;
    logic [CNT_W-1:0]       stableCnt;
    logic                   cleanClk;
    logic                   cleanClkDly;

    // Synchronisers reset to the idle-high bus level so that leaving reset
    // never manufactures a falling edge.
    always_ff @(posedge sysClock or negedge sysReset_n) begin
        if (!sysReset_n) begin
            clkSync     <= '1;
            datSync     <= '1;
            stableCnt   <= '0;
            cleanClk    <= 1'b1;
            cleanClkDly <= 1'b1;
        end else begin
            clkSync     <= {clkSync[SYNC_STAGES-2:0], keyClk};
            datSync     <= {datSync[SYNC_STAGES-2:0], keyData};
            cleanClkDly <= cleanClk;
            // The clean level only follows after FILTER_LEN consecutive samples
            // disagree with it; any agreeing sample restarts the count.
            if (clkSync[SYNC_STAGES-1] != cleanClk) begin
                if (stableCnt == CNT_W'(FILTER_LEN - 1)) begin
                    cleanClk  <= clkSync[SYNC_STAGES-1];
                    stableCnt <= '0;
                end else begin
                    stableCnt <= stableCnt + CNT_W'(1);
                end
            end else begin
                stableCnt <= '0;
            end
        end
    end

    assign fallEdge = cleanClkDly & ~cleanClk;
    assign dataSync = datSync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_controller.sv
// PS/2 keyboard frame receiver: collects 11-bit frames, checks start/parity/stop, hands bytes on.
// Latency: frameValid/errValid appear 2 cycles after the stop-bit fallEdge (one CHECK cycle between).
// Backpressure: frameValid holds until frameReady; keyClkInhibit holds the keyboard off meanwhile.
//
// Ports:
//   sysClock, sysReset_n  clock / async active-low reset
//   keyClk, keyData       raw PS/2 pins
//   frameReady            decoder accepts frameData this cycle
//   frameData/frameValid  received byte (LSB = first data bit) and its valid flag
//   errValid/errCode      one-cycle discard pulse and its reason (held until next pulse)
//   keyClkInhibit         1 = pull keyClk low while a byte waits for the decoder
//   busy                  1 whenever a frame is in progress or waiting
module ps2_rx_controller
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       sysClock,
    input  logic       sysReset_n,
    input  logic       keyClk,
    input  logic       keyData,
    input  logic       frameReady,
    output logic [7:0] frameData,
    output logic       frameValid,
    output logic       errValid,
    output logic [1:0] errCode,
    output logic       keyClkInhibit,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic fallEdge;
    logic dataSync;

    ps2_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_front (
        .sysClock   (sysClock),
        .sysReset_n (sysReset_n),
        .keyClk     (keyClk),
        .keyData    (keyData),
        .fallEdge   (fallEdge),
        .dataSync   (dataSync)
    );

    ps2_state_t    state, stateNext;
    logic [3:0]    bitCnt, bitCntNext;
    logic [9:0]    shreg, shregNext;      // frame bits 1..10 once complete: [7:0] data, [8] parity, [9] stop
    logic [TW-1:0] timer, timerNext;
    logic [7:0]    frameDataNext;
    logic          frameValidNext;
    logic          inhibitNext;
    logic          errValidNext;
    logic [1:0]    errCodeNext;

    always_ff @(posedge sysClock or negedge sysReset_n) begin
        if (!sysReset_n) begin
            state         <= IDLE;
            bitCnt        <= '0;
            shreg         <= '0;
            timer         <= '0;
            frameData     <= '0;
            frameValid    <= 1'b0;
            keyClkInhibit <= 1'b0;
            errValid      <= 1'b0;
            errCode       <= ERR_NONE;
        end else begin
            state         <= stateNext;
            bitCnt        <= bitCntNext;
            shreg         <= shregNext;
            timer         <= timerNext;
            frameData     <= frameDataNext;
            frameValid    <= frameValidNext;
            keyClkInhibit <= inhibitNext;
            errValid      <= errValidNext;
            errCode       <= errCodeNext;
        end
    end

    always_comb begin
        stateNext      = state;
        bitCntNext     = bitCnt;
        shregNext      = shreg;
        timerNext      = timer;
        frameDataNext  = frameData;
        frameValidNext = frameValid;
        inhibitNext    = keyClkInhibit;
        errValidNext   = 1'b0;
        errCodeNext    = errCode;

        case (state)
            IDLE: begin
                bitCntNext = '0;
                timerNext  = '0;
                // A fall with data high cannot be a start bit; stay put and let
                // the next genuine start bit realign us.
                if (fallEdge && !dataSync) begin
                    stateNext  = RECV;
                    bitCntNext = 4'd1;
                    shregNext  = '0;
                end
            end

            RECV: begin
                if (fallEdge) begin
                    shregNext = {dataSync, shreg[9:1]};
                    timerNext = '0;
                    if (bitCnt == 4'(STOP_IDX)) begin
                        stateNext = CHECK;
                    end else begin
                        bitCntNext = bitCnt + 4'd1;
                    end
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    errValidNext = 1'b1;
                    errCodeNext  = ERR_TIMEOUT;
                    stateNext    = IDLE;
                end else if (timer != {TW{1'b1}}) begin
                    timerNext = timer + TW'(1);
                end
            end

            CHECK: begin
                // Framing is judged before parity: with a bad stop bit the
                // parity position may not be where we think it is.
                if (!shreg[STOP_IDX-1]) begin
                    errValidNext = 1'b1;
                    errCodeNext  = ERR_FRAMING;
                    stateNext    = IDLE;
                end else if (!(^shreg[PARITY_IDX-1:0])) begin
                    errValidNext = 1'b1;
                    errCodeNext  = ERR_PARITY;
                    stateNext    = IDLE;
                end else begin
                    frameDataNext  = shreg[7:0];
                    frameValidNext = 1'b1;
                    inhibitNext    = 1'b1;
                    stateNext      = PRESENT;
                end
            end

            PRESENT: begin
                // Falls seen here are the keyboard racing our inhibit; they are
                // dropped and the IDLE start-bit rule plus timeout recover.
                if (frameReady) begin
                    frameValidNext = 1'b0;
                    inhibitNext    = 1'b0;
                    stateNext      = IDLE;
                end
            end

            default: stateNext = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
